// File: rtl/tlut_reduce_pkg.sv
// Shared constants and types for the TLUT product reduction path.
package tlut_reduce_pkg;

  localparam int unsigned DIM_A     = 4;
  localparam int unsigned DIM_C     = 8;
  localparam int unsigned ACC_WIDTH = 16;
  localparam int unsigned OUT_WIDTH = 24;

  function automatic int unsigned tree_levels(input int unsigned n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned TREE_LEVELS = tree_levels(DIM_C);

  typedef struct packed {
    logic first;
    logic last;
  } side_t;

endpackage

// File: rtl/tlut_adder_tree.sv
// One lane of the pipelined binary adder tree: N signed products -> one sum, L register levels.
module tlut_adder_tree #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 16,
  parameter int unsigned L = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic             out_valid,
  output logic             busy,
  output logic [W+L-1:0]   out_data
);

  localparam int unsigned P  = 1 << L;
  localparam int unsigned TW = W + L;

  logic [P*W-1:0]        w_pad;
  logic signed [TW-1:0]  w_val  [2*P];
  logic signed [TW-1:0]  r_node [1:P-1];
  logic [L-1:0]          r_vld;

  // Heap layout: node i sums children 2i and 2i+1; indices P..2P-1 are the
  // zero-padded leaves, so every level is exactly one register deep.
  always_comb begin
    w_pad = '0;
    w_pad[N*W-1:0] = in_data;
    w_val = '{default: '0};
    for (int unsigned i = 1; i < P; i++) w_val[i] = r_node[i];
    for (int unsigned k = 0; k < P; k++) w_val[P+k] = TW'($signed(w_pad[k*W +: W]));
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int unsigned i = 1; i < P; i++) r_node[i] <= w_val[2*i] + w_val[2*i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else if (adv) begin
      r_vld[0] <= in_valid;
      for (int unsigned j = 1; j < L; j++) r_vld[j] <= r_vld[j-1];
    end
  end

  assign out_valid = r_vld[L-1];
  assign out_data  = r_node[1];
  assign busy      = |r_vld;

endmodule

// File: rtl/tlut_reduce.sv
// Reduces per-lane TLUT products through adder trees, accumulates over a K-tile
// and emits one saturated sum per lane with valid/ready flow control.
module tlut_reduce #(
  parameter int unsigned DIM_A     = tlut_reduce_pkg::DIM_A,
  parameter int unsigned DIM_C     = tlut_reduce_pkg::DIM_C,
  parameter int unsigned ACC_WIDTH = tlut_reduce_pkg::ACC_WIDTH,
  parameter int unsigned OUT_WIDTH = tlut_reduce_pkg::OUT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0] in_prod,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DIM_A*OUT_WIDTH-1:0]       out_sum,
  output logic [DIM_A-1:0]                 out_sat,
  output logic                             seq_err,
  output logic                             busy
);

  import tlut_reduce_pkg::*;

  localparam int unsigned L     = tree_levels(DIM_C);
  localparam int unsigned TW    = ACC_WIDTH + L;
  localparam int unsigned SUM_W = max_u(OUT_WIDTH, TW) + 1;
  localparam logic signed [SUM_W-1:0] MAXV = {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MINV = {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic                         w_adv;
  logic [DIM_C*ACC_WIDTH-1:0]   w_lane_in [DIM_A];
  logic [TW-1:0]                w_tree    [DIM_A];
  logic [DIM_A-1:0]             w_lane_vld;
  logic [DIM_A-1:0]             w_lane_busy;
  side_t                        w_side;
  logic                         w_s_valid;
  logic                         w_fresh;
  logic signed [OUT_WIDTH-1:0]  w_nacc    [DIM_A];
  logic [DIM_A*OUT_WIDTH-1:0]   w_nacc_flat;
  logic [DIM_A-1:0]             w_nsat;

  logic signed [OUT_WIDTH-1:0]  r_acc     [DIM_A];
  logic [DIM_A-1:0]             r_acc_sat;
  logic                         r_acc_open;
  logic                         r_tile_open;
  logic                         r_seq_err;
  logic                         r_out_valid;
  logic [DIM_A*OUT_WIDTH-1:0]   r_out_sum;
  logic [DIM_A-1:0]             r_out_sat;

  assign w_adv    = !(r_out_valid && !out_ready);
  assign in_ready = w_adv;

  always_comb begin
    w_lane_in = '{default: '0};
    for (int unsigned a = 0; a < DIM_A; a++) begin
      for (int unsigned c = 0; c < DIM_C; c++) begin
        w_lane_in[a][c*ACC_WIDTH +: ACC_WIDTH] = in_prod[(c*DIM_A+a)*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  generate
    if (L == 0) begin : g_bypass
      for (genvar a = 0; a < DIM_A; a++) begin : g_lane
        assign w_tree[a] = w_lane_in[a];
      end
      assign w_lane_vld  = {DIM_A{in_valid}};
      assign w_lane_busy = '0;
      assign w_side      = {in_first, in_last};
    end else begin : g_tree
      side_t r_side [L];
      for (genvar a = 0; a < DIM_A; a++) begin : g_lane
        tlut_adder_tree #(
          .N (DIM_C),
          .W (ACC_WIDTH),
          .L (L)
        ) u_tree (
          .clk       (clk),
          .rst       (rst),
          .adv       (w_adv),
          .in_valid  (in_valid),
          .in_data   (w_lane_in[a]),
          .out_valid (w_lane_vld[a]),
          .busy      (w_lane_busy[a]),
          .out_data  (w_tree[a])
        );
      end
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_side[0] <= {in_first, in_last};
          for (int unsigned j = 1; j < L; j++) r_side[j] <= r_side[j-1];
        end
      end
      assign w_side = r_side[L-1];
    end
  endgenerate

  assign w_s_valid = &w_lane_vld;
  // Accumulator restarts on first, and is treated as zero when no tile is open.
  assign w_fresh   = w_side.first || !r_acc_open;

  always_comb begin
    w_nacc_flat = '0;
    w_nsat      = '0;
    for (int unsigned a = 0; a < DIM_A; a++) begin
      logic signed [SUM_W-1:0] v_base;
      logic signed [SUM_W-1:0] v_sum;
      logic                    v_clip;
      v_base    = w_fresh ? '0 : SUM_W'(r_acc[a]);
      v_sum     = v_base + SUM_W'($signed(w_tree[a]));
      v_clip    = 1'b0;
      w_nacc[a] = v_sum[OUT_WIDTH-1:0];
      if (v_sum > MAXV) begin
        w_nacc[a] = MAXV[OUT_WIDTH-1:0];
        v_clip    = 1'b1;
      end else if (v_sum < MINV) begin
        w_nacc[a] = MINV[OUT_WIDTH-1:0];
        v_clip    = 1'b1;
      end
      w_nsat[a] = (!w_fresh && r_acc_sat[a]) || v_clip;
      w_nacc_flat[a*OUT_WIDTH +: OUT_WIDTH] = w_nacc[a];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '{default: '0};
      r_acc_sat   <= '0;
      r_acc_open  <= 1'b0;
      r_tile_open <= 1'b0;
      r_seq_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_sat   <= '0;
    end else if (w_adv) begin
      if (w_s_valid) begin
        r_acc      <= w_nacc;
        r_acc_sat  <= w_nsat;
        r_acc_open <= !w_side.last && (w_side.first || r_acc_open);
      end
      r_out_valid <= w_s_valid && w_side.last;
      if (w_s_valid && w_side.last) begin
        r_out_sum <= w_nacc_flat;
        r_out_sat <= w_nsat;
      end
      if (in_valid) begin
        if (in_first && r_tile_open) r_seq_err <= 1'b1;
        r_tile_open <= !in_last && (in_first || r_tile_open);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_sat   = r_out_sat;
  assign seq_err   = r_seq_err;
  assign busy      = (|w_lane_busy) || r_out_valid || r_tile_open;

endmodule

// File: tb/tb_tlut_reduce.sv
// Directed bench for tlut_reduce: default instance plus a DIM_C=1, 16-bit saturation instance.
module tb_tlut_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         d_valid, d_first, d_last, d_ready;
  logic [511:0] d_prod;
  logic         d_in_ready, d_out_valid, d_seq_err, d_busy;
  logic [95:0]  d_out_sum;
  logic [3:0]   d_out_sat;

  logic         s_valid, s_first, s_last;
  logic [63:0]  s_prod;
  logic         s_in_ready, s_out_valid, s_seq_err, s_busy;
  logic [63:0]  s_out_sum;
  logic [3:0]   s_out_sat;

  int n_cmp = 0;
  int n_err = 0;
  int next_val;
  int q_rx[$];

  tlut_reduce u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_valid),
    .in_ready  (d_in_ready),
    .in_first  (d_first),
    .in_last   (d_last),
    .in_prod   (d_prod),
    .out_valid (d_out_valid),
    .out_ready (d_ready),
    .out_sum   (d_out_sum),
    .out_sat   (d_out_sat),
    .seq_err   (d_seq_err),
    .busy      (d_busy)
  );

  tlut_reduce #(
    .DIM_A     (4),
    .DIM_C     (1),
    .ACC_WIDTH (16),
    .OUT_WIDTH (16)
  ) u_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_valid),
    .in_ready  (s_in_ready),
    .in_first  (s_first),
    .in_last   (s_last),
    .in_prod   (s_prod),
    .out_valid (s_out_valid),
    .out_ready (1'b1),
    .out_sum   (s_out_sum),
    .out_sat   (s_out_sat),
    .seq_err   (s_seq_err),
    .busy      (s_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] lane(input int a);
    return d_out_sum[a*24 +: 24];
  endfunction

  task automatic set_lane(input int a, input logic [15:0] v);
    for (int c = 0; c < 8; c++) d_prod[(c*4+a)*16 +: 16] = v;
  endtask

  initial begin
    rst = 1'b1;
    d_valid = 1'b0; d_first = 1'b0; d_last = 1'b0; d_ready = 1'b1; d_prod = '0;
    s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_prod = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_in_ready", d_in_ready, 1);
    chk("rst_out_valid", d_out_valid, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_seq_err", d_seq_err, 0);
    chk("rst_out_sum", d_out_sum[31:0] | d_out_sum[63:32] | d_out_sum[95:64], 0);
    chk("rst_out_sat", d_out_sat, 0);
    chk("rst_s_in_ready", s_in_ready, 1);
    chk("rst_s_busy", s_busy, 0);

    // single window, lane0 = 1..8, other lanes all -1
    for (int c = 0; c < 8; c++) d_prod[(c*4)*16 +: 16] = 16'(c + 1);
    set_lane(1, 16'hFFFF); set_lane(2, 16'hFFFF); set_lane(3, 16'hFFFF);
    d_valid = 1'b1; d_first = 1'b1; d_last = 1'b1;
    step();
    d_valid = 1'b0;
    chk("t1_lat1", d_out_valid, 0);
    step(); chk("t1_lat2", d_out_valid, 0);
    step(); chk("t1_lat3", d_out_valid, 0);
    step();
    chk("t1_valid", d_out_valid, 1);
    chk("t1_lane0", lane(0), 24'd36);
    chk("t1_lane1", lane(1), 24'hFFFFF8);
    chk("t1_lane2", lane(2), 24'hFFFFF8);
    chk("t1_lane3", lane(3), 24'hFFFFF8);
    chk("t1_sat", d_out_sat, 0);
    step(); chk("t1_drop", d_out_valid, 0);

    // three-window tile of all-ones on lane0
    d_prod = '0; set_lane(0, 16'h0001);
    d_valid = 1'b1; d_first = 1'b1; d_last = 1'b0;
    step();
    chk("t2_busy", d_busy, 1);
    chk("t2_w1", d_out_valid, 0);
    d_first = 1'b0;
    step(); chk("t2_w2", d_out_valid, 0);
    d_last = 1'b1;
    step();
    d_valid = 1'b0; d_last = 1'b0;
    chk("t2_w3", d_out_valid, 0);
    step(); chk("t2_lat2", d_out_valid, 0);
    step(); chk("t2_lat3", d_out_valid, 0);
    step();
    chk("t2_valid", d_out_valid, 1);
    chk("t2_lane0", lane(0), 24'd24);
    chk("t2_lane1", lane(1), 24'd0);
    step(); chk("t2_drop", d_out_valid, 0);

    // backpressure while streaming single-window tiles 1..6
    d_prod = '0; d_first = 1'b1; d_last = 1'b1; next_val = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      d_ready = !(cyc >= 2 && cyc < 7);
      d_valid = (next_val <= 6);
      d_prod[15:0] = 16'(next_val);
      #1;
      if (cyc == 4 || cyc == 6) begin
        chk("t3_in_ready_low", d_in_ready, 0);
        chk("t3_stall_hold", lane(0), 24'd1);
      end
      if (d_out_valid && d_ready) q_rx.push_back(int'(lane(0)));
      if (d_valid && d_in_ready) next_val++;
      @(posedge clk);
      #1;
    end
    d_valid = 1'b0; d_first = 1'b0; d_last = 1'b0; d_ready = 1'b1;
    chk("t3_count", q_rx.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_order", (i < q_rx.size()) ? q_rx[i] : -1, i + 1);

    // saturation: DIM_C=1, 16-bit output, two windows of max then min
    s_prod = {4{16'h7FFF}}; s_valid = 1'b1; s_first = 1'b1; s_last = 1'b0;
    step();
    chk("t4_mid", s_out_valid, 0);
    s_first = 1'b0; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    chk("t4_pos_valid", s_out_valid, 1);
    chk("t4_pos_lane0", s_out_sum[15:0], 16'h7FFF);
    chk("t4_pos_lane3", s_out_sum[63:48], 16'h7FFF);
    chk("t4_pos_sat", s_out_sat, 4'hF);
    s_prod = {4{16'h8000}}; s_valid = 1'b1; s_first = 1'b1; s_last = 1'b0;
    step();
    s_first = 1'b0; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    chk("t4_neg_valid", s_out_valid, 1);
    chk("t4_neg_lane0", s_out_sum[15:0], 16'h8000);
    chk("t4_neg_lane2", s_out_sum[47:32], 16'h8000);
    chk("t4_neg_sat", s_out_sat, 4'hF);
    s_prod = {4{16'h7FFF}}; s_valid = 1'b1; s_first = 1'b1; s_last = 1'b1;
    step();
    s_valid = 1'b0;
    chk("t4_exact_max", s_out_sum[31:16], 16'h7FFF);
    chk("t4_exact_nosat", s_out_sat, 4'h0);
    chk("t4_seq_err", s_seq_err, 0);

    // reset two cycles after an accepted last group
    d_prod = '0; set_lane(0, 16'h0001);
    d_valid = 1'b1; d_first = 1'b1; d_last = 1'b1;
    step();
    d_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t5_out_valid", d_out_valid, 0);
    chk("t5_busy", d_busy, 0);
    chk("t5_in_ready", d_in_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_output", d_out_valid, 0);
    end
    set_lane(0, 16'h0002);
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    repeat (3) step();
    chk("t5_after_valid", d_out_valid, 1);
    chk("t5_after_lane0", lane(0), 24'd16);
    step();

    // first while a tile is open: restart and sticky seq_err
    d_prod = '0; set_lane(0, 16'h0001);
    d_valid = 1'b1; d_first = 1'b1; d_last = 1'b0;
    step();
    chk("t6_no_err", d_seq_err, 0);
    set_lane(0, 16'h0003);
    step();
    chk("t6_err", d_seq_err, 1);
    set_lane(0, 16'h0001);
    d_first = 1'b0; d_last = 1'b1;
    step();
    d_valid = 1'b0; d_last = 1'b0;
    repeat (3) step();
    chk("t6_valid", d_out_valid, 1);
    chk("t6_lane0", lane(0), 24'd32);
    repeat (3) step();
    chk("t6_err_sticky", d_seq_err, 1);
    chk("t6_drop", d_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
